// File: rtl/next_state_sequencer_if.sv
// Purpose : bundles the microsequencer's control inputs and status outputs so
//           the microinstruction side and the sequencer connect through one port.
// Signals :
//   nsCtrl[2:0]       next-state operation from the current microinstruction
//   crState[6:0]      microinstruction-supplied branch target
//   encState[6:0]     dispatch target from the instruction encoder
//   cond              condition tester result
//   moc               memory-operation-complete
//   currentState[6:0] registered microstate (microstore address)
//   stall             high while holding in a MOC wait
//   illegalState      one-cycle pulse when an out-of-range target was replaced by 0
//   mocTimeout        one-cycle pulse when a MOC wait timed out
// Modports: master drives the controls, slave is the sequencer itself.
interface next_state_sequencer_if;
    logic [2:0] nsCtrl;
    logic [6:0] crState;
    logic [6:0] encState;
    logic       cond;
    logic       moc;
    logic [6:0] currentState;
    logic       stall;
    logic       illegalState;
    logic       mocTimeout;

    modport master (
        output nsCtrl, crState, encState, cond, moc,
        input  currentState, stall, illegalState, mocTimeout
    );

    modport slave (
        input  nsCtrl, crState, encState, cond, moc,
        output currentState, stall, illegalState, mocTimeout
    );
endinterface

// File: rtl/next_state_sequencer.sv
// Purpose : microprogram next-state sequencer. Each cycle it picks the next
//           microstate from the nsCtrl operation (dispatch, jump, increment,
//           conditional branch, MOC wait, restart), replaces targets above
//           MAX_STATE with 0 and flags them, and stalls while memory is busy.
// Ports   :
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    next_state_sequencer_if.slave (controls in, state/status out)
// Params  :
//   MAX_STATE       highest legal microstate number
//   TRAP_STATE      state entered on a MOC timeout
//   TIMEOUT_CYCLES  stalled-cycle limit for a MOC wait (1..15)
// Build   : define MOC_TIMEOUT_EN to bound MOC waits with the timeout; without
//           it waits are unbounded, there is no wait counter and mocTimeout is 0.
module next_state_sequencer #(
    parameter int MAX_STATE      = 40,
    parameter int TRAP_STATE     = 5,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    next_state_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        NS_DISPATCH = 3'd0,
        NS_JUMP     = 3'd1,
        NS_INC      = 3'd2,
        NS_BR_T     = 3'd3,
        NS_BR_F     = 3'd4,
        NS_WAIT_INC = 3'd5,
        NS_WAIT_JMP = 3'd6,
        NS_RESTART  = 3'd7
    } ns_op_t;

    localparam logic [6:0] MAX_STATE_W  = 7'(MAX_STATE);
    localparam logic [6:0] TRAP_STATE_W = 7'(TRAP_STATE);

    // Parameter sanity, caught at elaboration rather than as odd behaviour.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..15");
    end
    if (MAX_STATE < 0 || MAX_STATE > 127 || TRAP_STATE < 0 || TRAP_STATE > MAX_STATE) begin : g_bad_state
        $error("MAX_STATE must be 0..127 and TRAP_STATE must not exceed it");
    end

    ns_op_t     op;
    logic [6:0] state_q;
    logic [6:0] inc_state;
    logic [6:0] target;
    logic       check_target;   // hold and restart results are never range-checked
    logic       illegal_target;
    logic       stall;
    logic       illegal_q;

    assign op        = ns_op_t'(bus.nsCtrl);
    assign inc_state = state_q + 7'd1;   // 7-bit modulo: 127 wraps to 0

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        target       = state_q;
        check_target = 1'b0;
        unique case (op)
            NS_DISPATCH: begin target = bus.encState; check_target = 1'b1; end
            NS_JUMP:     begin target = bus.crState;  check_target = 1'b1; end
            NS_INC:      begin target = inc_state;    check_target = 1'b1; end
            NS_BR_T:     begin target = bus.cond ? bus.crState : inc_state;  check_target = 1'b1; end
            NS_BR_F:     begin target = !bus.cond ? bus.crState : inc_state; check_target = 1'b1; end
            // moc is only looked at here; elsewhere it has no effect and is not stored.
            NS_WAIT_INC: begin target = bus.moc ? inc_state : state_q;   check_target = bus.moc; end
            NS_WAIT_JMP: begin target = bus.moc ? bus.crState : state_q; check_target = bus.moc; end
            NS_RESTART:  begin target = 7'd0; end
            default:     begin target = 7'd0; end
        endcase
    end

    assign illegal_target = check_target && (target > MAX_STATE_W);
    assign stall          = ((op == NS_WAIT_INC) || (op == NS_WAIT_JMP)) && !bus.moc;

    assign bus.currentState = state_q;
    assign bus.stall        = stall;
    assign bus.illegalState = illegal_q;

`ifdef MOC_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT_CYCLES - 1);

    logic [3:0] wait_cnt;
    logic       timeout_q;

    assign bus.mocTimeout = timeout_q;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Reset is synchronous and overrides everything, including a wait in progress.
            state_q   <= 7'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            wait_cnt  <= 4'd0;
        end else if (stall && (wait_cnt == TIMEOUT_LAST)) begin
            // Last allowed stalled cycle: give up and trap. A moc in this
            // cycle clears stall, so a completing memory access wins.
            state_q   <= TRAP_STATE_W;
            illegal_q <= 1'b0;
            timeout_q <= 1'b1;
            wait_cnt  <= 4'd0;
        end else begin
            state_q   <= illegal_target ? 7'd0 : target;
            illegal_q <= illegal_target;
            timeout_q <= 1'b0;
            wait_cnt  <= stall ? (wait_cnt + 4'd1) : 4'd0;
        end
    end
`else
    assign bus.mocTimeout = 1'b0;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Reset is synchronous and overrides everything, including a wait in progress.
            state_q   <= 7'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= illegal_target ? 7'd0 : target;
            illegal_q <= illegal_target;
        end
    end
`endif

endmodule

// File: doc/next_state_sequencer.md
NEXT_STATE_SEQUENCER -- requirements
Module: next_state_sequencer

Interface
REQ-001 The block SHALL have these parameters:
- MAX_STATE, 40, highest legal microstate number.
- TRAP_STATE, 5, state entered on a memory timeout.
- TIMEOUT_CYCLES, 15, wait-cycle limit (4-bit, 1..15).

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- nsCtrl  in  3  next-state operation from the current microinstruction.
- crState  in  7  microinstruction-supplied branch target.
- encState  in  7  dispatch target from the instruction encoder.
- cond  in  1  condition result from the condition tester.
- moc  in  1  memory-operation-complete from memory.
- currentState  out  7  registered microstate; drives the microstore address.
- stall  out  1  high while holding in a MOC wait.
- illegalState  out  1  one-cycle pulse when a target exceeds MAX_STATE.
- mocTimeout  out  1  one-cycle pulse on a MOC timeout.

Function
REQ-003 currentState SHALL update only on a rising clk edge; next state is combinational from the inputs and currentState (latency 1 cycle).

REQ-004 nsCtrl decode SHALL be:
- 0 DISPATCH: encState.
- 1 JUMP: crState.
- 2 INC: currentState+1.
- 3 BR_T: crState if cond, else +1.
- 4 BR_F: crState if !cond, else +1.
- 5 WAIT_INC: +1 if moc, else hold.
- 6 WAIT_JMP: crState if moc, else hold.
- 7 RESTART: 0.

REQ-005 Increment SHALL be 7-bit modulo; 127+1 wraps to 0.

REQ-006 A selected target greater than MAX_STATE SHALL load 0 and pulse illegalState in the cycle the illegal state would have been loaded. Hold and wrap results are not checked.

REQ-007 stall SHALL be combinational: 1 when nsCtrl is 5 or 6 and moc=0, else 0.

REQ-008 moc SHALL be sampled only under nsCtrl 5 or 6; a moc pulse in any other state SHALL be ignored and not remembered.

REQ-009 cond SHALL be sampled only under nsCtrl 3 or 4.

REQ-010 The wait counter (4-bit) SHALL increment on each stalled cycle and clear on any cycle without a stall.

REQ-011 moc=1 on the first wait cycle SHALL advance with zero stall cycles.

Reset
REQ-012 reset=1 at a rising edge SHALL set currentState=0, wait counter=0, illegalState=0 and mocTimeout=0, overriding every other input.

REQ-013 Reset asserted mid-wait SHALL abort the wait; state 0 is entered on the next edge.

REQ-014 For the whole first cycle after reset deasserts, currentState SHALL be 0.

Configuration
REQ-015 With MOC_TIMEOUT_EN defined, the timeout SHALL apply: a stalled cycle whose counter value equals TIMEOUT_CYCLES-1 loads TRAP_STATE, pulses mocTimeout for one cycle and clears the counter.
- moc=1 in that same cycle SHALL take priority: normal advance, no timeout.

REQ-016 Without MOC_TIMEOUT_EN, the wait SHALL be unbounded, the counter logic SHALL be absent and mocTimeout SHALL be tied to 0.

Verification
REQ-017 Reset then DISPATCH with encState=12 -> currentState 0, then 12 on the next edge.

REQ-018 currentState=3, nsCtrl=3, crState=20:
- cond=1 -> 20.
- Repeat with cond=0 -> 4.
- nsCtrl=4 with cond=0 -> 20.

REQ-019 nsCtrl=5 at state 7, moc=0 for 4 cycles then 1 -> stall high for 4 cycles, currentState stays 7, then becomes 8 with stall low.

REQ-020 MOC_TIMEOUT_EN, TIMEOUT_CYCLES=15, moc held 0 at state 9 under nsCtrl=6 -> after 15 stalled cycles currentState=5 and mocTimeout high for exactly 1 cycle. Without the macro, the state stays at 9 for 100 or more cycles.

REQ-021 Edge cases:
- DISPATCH with encState=45 -> currentState 0 and an illegalState pulse.
- INC at state 127 (forced through a bench override) -> 0 with no illegalState.

REQ-022 reset asserted on the 3rd stall cycle of a wait -> currentState 0 at the next edge, counter 0, and no mocTimeout in the following 20 cycles with nsCtrl=7.
